serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor that computes `diff = a - b - bin` LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the combinational full adder and sits in the same arithmetic library. It suits area-constrained datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake frames each operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge.
- `bin`  input  1  borrow-in; sampled on the accepting edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle completion pulse.
- `diff`  output  WIDTH  registered result, held until the next completion.
- `bout`  output  1  registered borrow-out of the MSB stage.
- `ovf`  output  1  signed overflow; present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is defined in the package.
- **IDLE → SHIFT** when `start`=1.
  - Latch `a` and `b` into shift registers.
  - Load the borrow flip-flop with `bin`.
  - Clear the bit counter.
- **SHIFT**, each cycle:
  - `d = a0 ^ b0 ^ br`.
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift `d` into the MSB of the result shift register.
  - Shift the `a` and `b` registers right by one.
  - Increment the counter.
- **SHIFT → DONE** on the edge that processes bit WIDTH-1.
  - On that same edge, the `diff` output register takes the full result.
  - `bout` takes `br_next`.
- **DONE → SHIFT** if `start`=1, so back-to-back operations need no idle gap. Otherwise DONE → IDLE.
- `start` is ignored in SHIFT. The operands in flight are unaffected.
- Arithmetic is modulo 2^WIDTH.
  - `diff = (a - b - bin) mod 2^WIDTH`.
  - `bout = 1` iff a < b + bin, with both operands treated as unsigned.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `busy`, `done`, `diff`, `bout`, `ovf`, the counter, the borrow flip-flop and the shift registers all clear to 0.
  - An operation in progress is aborted with no `done`.

## Timing
- `start` is accepted at edge E.
  - `busy`=1 in the cycles following edges E … E+WIDTH-1.
  - `busy` falls after edge E+WIDTH.
- Edge E+WIDTH:
  - `diff`, `bout` and `ovf` become valid.
  - `done`=1 for exactly one cycle.
- Latency: start-to-done is WIDTH cycles, i.e. `done` asserts WIDTH edges after acceptance.
- Throughput: one result per WIDTH cycles when `start` is asserted in DONE.
- `busy` and `done` are never both high.
- Results change only on a completion edge. They are stable at all other times.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - On the completion edge, `ovf = br_in_msb ^ br_next`, the borrow into the MSB stage XOR the borrow out of it.
  - `ovf` is held with `diff` and reset to 0.
- **Undefined:**
  - Port `ovf` is absent.
  - No logic is generated for it. All other behaviour is identical.

## Structure
- Package `serial_subtractor_pkg`:
  - State enum `sub_state_t` {IDLE, SHIFT, DONE}.
  - Counter-width function `$clog2(WIDTH)`.
- Sub-module `full_subtractor`:
  - Inputs `a`, `b`, `bin`; outputs `d`, `bout`; purely combinational.
  - Instantiated once, in the SHIFT datapath.
- The top level holds the FSM, the counter, the shift registers, the borrow flip-flop and the output registers.

## Test plan
- WIDTH=8: `a`=100, `b`=37, `bin`=0 → after 8 cycles `done` pulses. Required: `diff`=63, `bout`=0, `ovf`=0.
- `a`=5, `b`=10, `bin`=0 → `diff`=251, `bout`=1. Required: `ovf`=0.
- `a`=8'h80, `b`=8'h01 → `diff`=8'h7F, `bout`=0. Required: `ovf`=1 when the macro is defined.
- `a`=0, `b`=0, `bin`=1 → `diff`=8'hFF. Required: `bout`=1, `ovf`=0.
- Pulse `start` with new operands at cycle 3 of SHIFT → ignored. Required: the original result completes.
- Back-to-back and reset, two cases:
  - `start` held in the DONE cycle → the second result arrives 8 cycles later, with no IDLE cycle between.
  - `rst_n` low mid-SHIFT → all outputs are 0 and no `done` pulse occurs.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit-counter width for a given operand width (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sub_state_t       state;
  sub_state_t       state_next;
  logic             accept_c;
  logic             last_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             br_next_c;
  logic [WIDTH-1:0] res_c;

  // One full-subtractor cell processes the current LSBs with the stored borrow
  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_c),
    .bout (br_next_c)
  );

  // Result as it stands once the current bit is shifted in
  assign res_c = {d_c, r_sr};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE or DONE
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          accept_c   = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = DONE;
          last_c     = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = SHIFT;
          accept_c   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered handshake outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  // Operand load and per-bit shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept_c) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr <= res_c[WIDTH-1:1];
      br   <= br_next_c;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers update only on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_c) begin
      diff <= res_c;
      bout <= br_next_c;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= 1'b0;
    else if (last_c) ovf <= br ^ br_next_c;
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), table-driven plus
// directed multi-cycle sequences. Checks ovf when SERIAL_SUBTRACTOR_OVF_EN is set.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;
  localparam int          BOUND = 3 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands with start for one accepting edge, then wait for done.
  // lat = number of edges after acceptance until done is seen.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vbin, output int lat);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!done && lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
      if (busy && done) chk("busy_done_exclusive", 1, 0);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_latency"}, lat, WIDTH);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_low"}, int'(busy), 0);
    chk({tag, "_diff"}, int'(diff), int'(v.diff));
    chk({tag, "_bout"}, int'(bout), int'(v.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({tag, "_ovf"}, int'(ovf), int'(v.ovf));
`endif
  endtask

  initial begin
    int   lat;
    int   seen;
    vec_t v;

    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1, 1'b0};
    vecs[2] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
    vecs[3] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0};
    vecs[4] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0};
    vecs[5] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
    vecs[6] = '{8'hAA,  8'h55,  1'b0, 8'h55,  1'b0, 1'b1};
    vecs[7] = '{8'h10,  8'h0F,  1'b1, 8'h00,  1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors, each followed by one idle cycle to check hold
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
      chk($sformatf("vec%0d_diff_held", i), int'(diff), int'(vecs[i].diff));
    end

    // start pulsed mid-SHIFT with new operands must be ignored
    a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    a = 8'd1; b = 8'd2; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < BOUND) begin @(posedge clk); #1; lat++; end
    check_result("ignore_start", vecs[0], lat);
    @(posedge clk); #1;
    chk("ignore_start_no_restart", int'(busy), 0);

    // Back-to-back: start held in the DONE cycle
    run_op(8'h80, 8'h01, 1'b0, lat);
    check_result("b2b_first", vecs[2], lat);
    run_op(8'd5, 8'd10, 1'b0, lat);
    check_result("b2b_second", vecs[1], lat);

    // Reset mid-SHIFT aborts with all outputs zero and no done
    a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_diff_held", int'(diff), 0);

    // Recovery after abort
    v = vecs[6];
    run_op(v.a, v.b, v.bin, lat);
    check_result("recover", v, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
